// File: rtl/posit_pack_sf.sv
// posit_pack_sf: packs a normalized sign / scale / 1.f mantissa into a posit(WIDTH,EXP) word.
// Latency 3 cycles, throughput 1 beat/cycle; every stage freezes while vld_o is held by rdy_i=0.
// Build macro POSIT_PACK_RNE_EN selects round-to-nearest-even; without it the fraction is truncated.
module posit_pack_sf #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int MTS   = WIDTH - 3 - EXP,
  parameter int REGI  = $clog2(WIDTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic                    vld_i,
  output logic                    rdy_o,
  input  logic                    sign_i,
  input  logic                    ovf_i,
  input  logic                    udf_i,
  input  logic                    nzero_i,
  input  logic signed [REGI+EXP:0] sf_i,
  input  logic [2*MTS+1:0]        mts_i,
  output logic                    vld_o,
  input  logic                    rdy_i,
  output logic [WIDTH-1:0]        posit_o
);

  localparam int FW = 2*MTS + 1;         // fraction bits below the hidden one
  localparam int TW = EXP + FW;          // exponent + fraction tail behind the regime
  localparam int NW = 2 + TW + WIDTH;    // regime seed + tail + headroom for the regime shift
  localparam int BW = WIDTH - 1;         // posit body (everything but the sign bit)
  localparam logic signed [REGI:0] KMAX = (REGI+1)'(WIDTH - 2);
  localparam logic signed [REGI:0] KMIN = -KMAX;

  typedef enum logic [1:0] {C_NORM, C_ZERO, C_MAX, C_MIN} cls_t;

  logic stall;

  // stage 1 registers
  logic                   s1_vld;
  logic                   s1_sign;
  cls_t                   s1_cls;
  logic signed [REGI:0]   s1_k;
  logic [EXP-1:0]         s1_e;
  logic [FW-1:0]          s1_frac;

  // stage 2 registers
  logic                   s2_vld;
  logic                   s2_sign;
  cls_t                   s2_cls;
  logic [BW-1:0]          s2_body;
`ifdef POSIT_PACK_RNE_EN
  logic                   s2_guard;
  logic                   s2_sticky;
`endif

  // combinational stage results
  logic signed [REGI:0]   k_c;
  cls_t                   cls_c;
  logic [REGI:0]          sh_c;
  logic signed [NW-1:0]   seed_c;
  logic signed [NW-1:0]   shifted_c;
  logic [BW-1:0]          body_c;
  logic                   inc_c;
  logic [BW:0]            sum_c;
  logic [BW-1:0]          rbody_c;
  logic [BW-1:0]          fbody_c;
  logic [WIDTH-1:0]       pos_c;

  // The hidden one is implied by the posit format, so it never reaches the word.
  logic hidden_unused;
  assign hidden_unused = mts_i[2*MTS+1];

  assign stall = vld_o & ~rdy_i;
  assign rdy_o = ~stall;

  // S1: split scale into regime index k and exponent bits, classify the beat
  always_comb begin
    k_c   = (REGI+1)'(sf_i >>> EXP);
    cls_c = C_NORM;
    if (!nzero_i)                     cls_c = C_ZERO;
    else if (ovf_i || (k_c > KMAX))   cls_c = C_MAX;
    else if (udf_i || (k_c < KMIN))   cls_c = C_MIN;
  end

  // S2: an arithmetic shift of "10" (k>=0) or "01" (k<0) grows the regime run in front of the tail
  always_comb begin
    sh_c      = s1_k[REGI] ? ~s1_k : s1_k;
    seed_c    = {(s1_k[REGI] ? 2'b01 : 2'b10), s1_e, s1_frac, {WIDTH{1'b0}}};
    shifted_c = seed_c >>> sh_c;
    body_c    = BW'(shifted_c >> (NW - BW));
  end

  // S3: round, clamp into [minpos, maxpos], apply class overrides and the sign
  always_comb begin
`ifdef POSIT_PACK_RNE_EN
    inc_c = s2_guard & (s2_body[0] | s2_sticky);
`else
    inc_c = 1'b0;
`endif
    sum_c = {1'b0, s2_body} + {{BW{1'b0}}, inc_c};
    if (sum_c[BW])
      rbody_c = '1;
    else if (sum_c[BW-1:0] == '0)
      rbody_c = {{(BW-1){1'b0}}, 1'b1};
    else
      rbody_c = sum_c[BW-1:0];

    case (s2_cls)
      C_MAX:   fbody_c = '1;
      C_MIN:   fbody_c = {{(BW-1){1'b0}}, 1'b1};
      default: fbody_c = rbody_c;
    endcase

    if (s2_cls == C_ZERO)
      pos_c = '0;
    else if (s2_sign)
      pos_c = (~{1'b0, fbody_c}) + WIDTH'(1);
    else
      pos_c = {1'b0, fbody_c};
  end

  // pipeline registers: all stages advance together unless the output is stalled
  always_ff @(posedge clk_i) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_cls    <= C_ZERO;
      s1_k      <= '0;
      s1_e      <= '0;
      s1_frac   <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_cls    <= C_ZERO;
      s2_body   <= '0;
`ifdef POSIT_PACK_RNE_EN
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
`endif
      vld_o     <= 1'b0;
      posit_o   <= '0;
    end else if (!stall) begin
      s1_vld    <= vld_i;
      s1_sign   <= sign_i;
      s1_cls    <= cls_c;
      s1_k      <= k_c;
      s1_e      <= sf_i[EXP-1:0];
      s1_frac   <= mts_i[FW-1:0];
      s2_vld    <= s1_vld;
      s2_sign   <= s1_sign;
      s2_cls    <= s1_cls;
      s2_body   <= body_c;
`ifdef POSIT_PACK_RNE_EN
      s2_guard  <= shifted_c[NW-1-BW];
      s2_sticky <= |shifted_c[NW-2-BW:0];
`endif
      vld_o     <= s2_vld;
      posit_o   <= s2_vld ? pos_c : '0;
    end
  end

endmodule

// File: tb/tb_posit_pack_sf.sv
// tb_posit_pack_sf: table vectors, stall/reset/latency sequences and random beats for posit_pack_sf.
// Expected words come from the vector table or from a bit-string posit encoder model.
// The output side is tracked with a queue of expected words in acceptance order.
module tb_posit_pack_sf;

`ifdef POSIT_PACK_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic       clk_i   = 1'b0;
  logic       rst     = 1'b1;
  logic       vld_i   = 1'b0;
  logic       rdy_o;
  logic       sign_i  = 1'b0;
  logic       ovf_i   = 1'b0;
  logic       udf_i   = 1'b0;
  logic       nzero_i = 1'b1;
  logic [6:0] sf_i    = '0;
  logic [7:0] mts_i   = '0;
  logic       vld_o;
  logic       rdy_i   = 1'b1;
  logic [7:0] posit_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp = '0;

  typedef struct {
    logic       s;
    logic       ov;
    logic       ud;
    logic       nz;
    int         sf;
    logic [7:0] m;
    logic [7:0] e;
  } vec_t;
  vec_t tbl[$];

  posit_pack_sf #(.WIDTH(8), .EXP(2)) dut (
    .clk_i   (clk_i),
    .rst     (rst),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .sign_i  (sign_i),
    .ovf_i   (ovf_i),
    .udf_i   (udf_i),
    .nzero_i (nzero_i),
    .sf_i    (sf_i),
    .mts_i   (mts_i),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .posit_o (posit_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference posit(8,2) encoder: write the bit string out, cut it at 7 bits, round, clamp.
  function automatic logic [7:0] ref_posit(input logic s, input logic ov, input logic ud,
                                           input logic nz, input int sf, input logic [7:0] m);
    int k, e, mag;
    bit q[$];
    bit g, st;
    if (!nz) return 8'h00;
    k = (sf >= 0) ? sf / 4 : -((-sf + 3) / 4);   // floor(sf / 4)
    e = sf - 4 * k;
    if (ov || k > 6) mag = 127;
    else if (ud || k < -6) mag = 1;
    else begin
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 1; i >= 0; i--) q.push_back(e[i]);
      for (int i = 6; i >= 0; i--) q.push_back(m[i]);
      mag = 0;
      for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
      g  = q[7];
      st = 1'b0;
      for (int i = 8; i < q.size(); i++) st = st | q[i];
      if (RNE && g && ((mag % 2 == 1) || st)) mag = mag + 1;
      if (mag > 127) mag = 127;
      if (mag == 0) mag = 1;
    end
    return s ? 8'(256 - mag) : 8'(mag);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic apply(input logic s, input logic ov, input logic ud, input logic nz,
                       input int sf, input logic [7:0] m);
    sign_i  = s;
    ovf_i   = ov;
    udf_i   = ud;
    nzero_i = nz;
    sf_i    = 7'(sf);
    mts_i   = m;
  endtask

  task automatic add(input logic s, input logic ov, input logic ud, input logic nz,
                     input int sf, input logic [7:0] m, input logic [7:0] e);
    vec_t v;
    v.s = s; v.ov = ov; v.ud = ud; v.nz = nz; v.sf = sf; v.m = m; v.e = e;
    tbl.push_back(v);
  endtask

  // One clock: score the beat leaving this cycle, log the beat entering, advance to next negedge.
  task automatic cycle(output bit acc);
    logic [7:0] want;
    #1;
    if (vld_o && rdy_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %02h, required no beat", posit_o);
      end else begin
        want = exp_q.pop_front();
        check("beat", int'(posit_o), int'(want));
        check("never_nar", int'(posit_o == 8'h80), 0);
      end
    end
    acc = vld_i && rdy_o;
    if (acc) exp_q.push_back(cur_exp);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    vld_i = 1'b0;
    rdy_i = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      cycle(a);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) cycle(a);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit a;
    int beat, cyc;
    logic [7:0] sb_m[5];
    int sb_sf[5];
    logic sb_s[5];

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_vld", int'(vld_o), 0);
    check("reset_posit", int'(posit_o), 0);
    check("reset_rdy", int'(rdy_o), 1);
    @(negedge clk_i);
    rst = 1'b0;

    // directed table: s, ovf, udf, nzero, sf, mts, expected
    add(0, 0, 0, 1,   0, 8'h80, 8'h40);
    add(0, 0, 0, 1,   1, 8'h80, 8'h48);
    add(0, 0, 0, 1,  -1, 8'h80, 8'h38);
    add(1, 0, 0, 1,   0, 8'h80, 8'hC0);
    add(1, 0, 0, 1,  -1, 8'h80, 8'hC8);
    add(0, 0, 0, 1,   0, 8'h98, RNE ? 8'h42 : 8'h41);
    add(0, 0, 0, 1,   0, 8'h88, 8'h40);
    add(0, 1, 0, 1,   0, 8'h80, 8'h7F);
    add(1, 1, 0, 1,   0, 8'h80, 8'h81);
    add(0, 0, 0, 1,  24, 8'h80, 8'h7F);
    add(0, 0, 0, 1, -30, 8'h80, 8'h01);
    add(0, 0, 1, 1,   0, 8'h80, 8'h01);
    add(1, 0, 0, 0,   5, 8'hC0, 8'h00);
    add(0, 1, 1, 1,   0, 8'h80, 8'h7F);
    add(0, 0, 0, 1, -24, 8'h80, 8'h01);
    add(0, 0, 0, 1, -21, 8'h80, RNE ? 8'h02 : 8'h01);
    add(1, 0, 0, 1,  27, 8'hFF, 8'h81);
    add(0, 0, 0, 1,  28, 8'h80, 8'h7F);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].s, tbl[i].ov, tbl[i].ud, tbl[i].nz, tbl[i].sf, tbl[i].m);
      cur_exp = tbl[i].e;
      vld_i = 1'b1;
      rdy_i = 1'b1;
      cycle(a);
      check($sformatf("vec%0d_accepted", i), int'(a), 1);
      drain();
    end

    // five back-to-back beats with the sink stalled for two cycles mid-stream
    for (int i = 0; i < 5; i++) begin
      sb_s[i]  = 1'($urandom);
      sb_sf[i] = int'($urandom_range(0, 40)) - 20;
      sb_m[i]  = {1'b1, 7'($urandom)};
    end
    beat = 0;
    cyc  = 0;
    while (beat < 5 && cyc < 40) begin
      apply(sb_s[beat], 1'b0, 1'b0, 1'b1, sb_sf[beat], sb_m[beat]);
      cur_exp = ref_posit(sb_s[beat], 1'b0, 1'b0, 1'b1, sb_sf[beat], sb_m[beat]);
      vld_i = 1'b1;
      rdy_i = !(cyc == 3 || cyc == 4);
      if (cyc == 3 || cyc == 4) begin
        #1;
        check("stall_rdy", int'(rdy_o), 0);
        check("stall_vld", int'(vld_o), 1);
        check("stall_hold", int'(posit_o), int'(exp_q[0]));
      end
      cycle(a);
      if (a) beat++;
      cyc++;
    end
    check("stream_beats_sent", beat, 5);
    drain();

    // reset with three beats in flight
    rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, i, 8'hA0);
      cur_exp = ref_posit(1'b0, 1'b0, 1'b0, 1'b1, i, 8'hA0);
      vld_i = 1'b1;
      cycle(a);
    end
    vld_i = 1'b0;
    rst   = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_vld", int'(vld_o), 0);
    check("midrst_posit", int'(posit_o), 0);

    // first beat after reset: valid exactly three edges after acceptance
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h80);
    vld_i = 1'b1;
    rdy_i = 1'b1;
    #1;
    check("lat_accept", int'(rdy_o), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    vld_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("lat_vld_edge%0d", i), int'(vld_o), (i == 3) ? 1 : 0);
      if (i < 3) begin
        @(posedge clk_i);
        @(negedge clk_i);
      end
    end
    check("lat_posit", int'(posit_o), 8'h48);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("lat_single", int'(vld_o), 0);
    @(negedge clk_i);

    // random beats with random sink backpressure against the model
    for (int i = 0; i < 400; i++) begin
      logic s, ov, ud, nz;
      int sf;
      logic [7:0] m;
      s  = 1'($urandom);
      ov = ($urandom_range(0, 15) == 0);
      ud = ($urandom_range(0, 15) == 0);
      nz = ($urandom_range(0, 15) != 0);
      sf = int'($urandom_range(0, 56)) - 28;
      m  = {1'b1, 7'($urandom)};
      apply(s, ov, ud, nz, sf, m);
      cur_exp = ref_posit(s, ov, ud, nz, sf, m);
      vld_i = ($urandom_range(0, 3) != 0);
      rdy_i = ($urandom_range(0, 4) != 0);
      cycle(a);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/posit_pack_sf.md
Name: posit_pack_sf

Overview:
- Posit encoder at the output end of the fused-dot-product datapath.
- Consumes the normalized result of the accumulator-fraction stage and produces a standard posit(WIDTH, EXP) word:
  - inputs: sign, signed scale factor, 1.f mantissa, overflow/underflow/non-zero flags
  - output: one posit word with regime/exponent/fraction packing, rounding, saturation and two's-complement negation
- 3-stage pipeline with valid/ready backpressure.

Parameters:
- WIDTH, 8, posit word width.
- EXP, 2, posit exponent-field width (es).
- MTS, WIDTH-3-EXP, per-operand fraction width. The input mantissa is 2*MTS+2 bits.
- REGI, $clog2(WIDTH)+1, regime-index width. The scale factor is REGI+EXP+1 bits, signed.

Ports:
- clk_i  in  1  clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- vld_i  in  1  input beat valid.
- rdy_o  out  1  block can accept a beat this cycle.
- sign_i  in  1  result sign (1 = negative).
- ovf_i  in  1  magnitude is at or above maxpos.
- udf_i  in  1  magnitude is below the representable scale.
- nzero_i  in  1  0 = exact zero result.
- sf_i  in  REGI+EXP+1  signed scale factor (power of two).
- mts_i  in  2*MTS+2  mantissa in 1.f format; bit [2*MTS+1] is the hidden one.
- vld_o  out  1  output beat valid.
- rdy_i  in  1  downstream accepts the beat.
- posit_o  out  WIDTH  encoded posit.

Behaviour:
- Reset: rst=1 at a clock edge clears all stage valids, vld_o=0 and posit_o=0.
  - Reset mid-operation discards all in-flight beats; no partial output is produced.
- Handshake:
  - stall = vld_o & ~rdy_i; rdy_o = ~stall.
  - While stalled, every stage register holds.
  - Otherwise all stages advance and the input is captured when vld_i=1.
  - A bubble propagates as a 0 valid.
  - posit_o and vld_o stay stable while stalled.
- Latency: 3 cycles from accepted input to vld_o with no stall. Throughput is 1 beat per cycle.
- S1 (decompose):
  - k = sf_i >>> EXP (arithmetic shift); e = sf_i[EXP-1:0].
  - Classify the beat, highest priority first:
    - ZERO: nzero_i=0.
    - MAX: ovf_i=1, or k > WIDTH-2.
    - MIN: udf_i=1, or k < -(WIDTH-2).
    - NORMAL: otherwise.
  - Register sign, class, k, e and the fraction mts_i[2*MTS:0].
- S2 (assemble):
  - Regime: k>=0 gives k+1 ones then a terminating 0; k<0 gives -k zeros then a terminating 1.
  - Concatenate regime | e | fraction into an unrounded body, left-aligned to WIDTH-1 bits.
  - Capture guard = first dropped bit and sticky = OR of all remaining dropped bits.
  - The regime may consume the whole body. k=WIDTH-2 gives 7 ones for WIDTH=8 with no terminator, and the dropped bits feed guard/sticky.
- S3 (round/finish):
  - Rounding: body + (guard & (lsb | sticky)).
  - If the rounded body would be all zeros, force 0...01 (minpos). If it carries out past all ones, force 1...1 (maxpos). Rounding never produces zero or NaR.
  - Class overrides:
    - MAX gives body all ones.
    - MIN gives body 0...01.
    - ZERO gives posit 0 regardless of sign.
  - Output: posit_o = {0, body}, two's-complemented when sign=1 (except ZERO).
- NaR (1 followed by zeros) is never emitted.
- Simultaneous ovf_i and udf_i: ovf_i wins.

Optional Feature:
- Macro POSIT_PACK_RNE_EN.
  - Defined: round-to-nearest-even as above.
  - Undefined: truncation. The increment is always 0, and guard/sticky registers may be removed. The minpos floor for non-zero values and the MAX/MIN/ZERO overrides still apply.

Test Plan (WIDTH=8, EXP=2):
- sf=0, mts=8'h80, sign=0, flags ovf=0 udf=0 nzero=1 -> posit_o=8'h40 after 3 cycles. sf=1 -> 8'h48. sf=-1 -> 8'h38. sign=1, sf=0 -> 8'hC0.
- sf=0, mts=8'b1001_1000 (tie, lsb=1) -> 8'h42 with RNE. Without the macro -> 8'h41. mts=8'b1000_1000 -> 8'h40 in both builds.
- Saturation cases:
  - ovf=1 -> 8'h7F; ovf=1 with sign=1 -> 8'h81.
  - sf=24 -> 8'h7F.
  - sf=-30 -> 8'h01.
  - udf=1 with nzero=1 -> 8'h01.
  - nzero=0 with sign=1 -> 8'h00.
- Back-to-back stream of 5 beats with rdy_i held low for 2 cycles mid-stream: no beat lost or duplicated, posit_o stable while stalled, order preserved, rdy_o=0 during the stall.
- rst asserted with 3 beats in flight -> vld_o=0 and posit_o=0 on the next cycle. A first beat after reset emerges 3 cycles after acceptance.
- Random sf in [-28,28] with random mts and sign, compared against a behavioural posit encoder model -> bit-exact match, never 8'h80.
